// File: rtl/ahb_pkg.sv
// Shared AHB encodings and response-router state for the data-phase return path.
package ahb_pkg;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_DERR1,
    ST_DERR2,
    ST_TERR1,
    ST_TERR2
  } rsp_state_e;

  // NONSEQ/SEQ start a data phase; IDLE/BUSY do not.
  function automatic logic is_xfer(input logic [1:0] htrans);
    return (htrans == 2'b10) || (htrans == 2'b11);
  endfunction

  // 2'b11 is an arbiter fault; M0 owns it.
  function automatic logic [1:0] norm_owner(input logic [1:0] sel);
    return (sel == 2'b11) ? 2'b01 : sel;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Two-cycle AHB ERROR generator: HREADY low with ERROR, then HREADY high with ERROR.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       err_first,
  input  logic       err_last,
  output logic       hready,
  output logic [1:0] hresp
);

  assign hready = !err_first;
  assign hresp  = (err_first || err_last) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_router.sv
// Routes the slave data-phase response to the owning master and drives global HREADY.
// Optional wait-state timeout with sticky irq when AHB_RESP_TIMEOUT_EN is defined.
module ahb_resp_router
  import ahb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [1:0]    hmsel,
  input  logic [1:0]    HTRANSM,
  input  logic          HSELSLV,
  input  logic [DW-1:0] HRDATAS,
  input  logic          HREADYOUTS,
  input  logic [1:0]    HRESPS,
  output logic          HREADYM,
  output logic [DW-1:0] HRDATAM0,
  output logic [DW-1:0] HRDATAM1,
  output logic          HREADYM0,
  output logic          HREADYM1,
  output logic [1:0]    HRESPM0,
  output logic [1:0]    HRESPM1,
  output logic [1:0]    dp_owner,
  output logic          timeout_irq,
  input  logic          timeout_clr
);

  rsp_state_e    state_q, state_d;
  logic [1:0]    own_q, own_d;
  logic          accept;
  logic          to_hit;
  logic          rdy;
  logic [1:0]    resp;
  logic [DW-1:0] data;
  logic          dflt_rdy;
  logic [1:0]    dflt_resp;

`ifdef AHB_RESP_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  // The timeout fires on the TIMEOUT_CYC-th wait, so the count reads TIMEOUT_CYC on entry to TERR1.
  assign to_hit = (state_q == ST_PASS) && !HREADYOUTS && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_PASS && !HREADYOUTS) cnt_d = cnt_q + 1'b1;
    irq_d = to_hit || (irq_q && !timeout_clr);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign timeout_irq = irq_q;
`else
  logic unused_cfg;
  assign to_hit      = 1'b0;
  assign timeout_irq = 1'b0;
  assign unused_cfg  = timeout_clr ^ (TIMEOUT_CYC >= (1 << CNT_W));
`endif

  assign accept = rdy;
  assign own_d  = accept ? norm_owner(hmsel) : own_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      own_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (!is_xfer(HTRANSM)) state_d = ST_IDLE;
      else if (HSELSLV)      state_d = ST_PASS;
      else                   state_d = ST_DERR1;
    end else begin
      case (state_q)
        ST_PASS:  if (to_hit) state_d = ST_TERR1;
        ST_DERR1: state_d = ST_DERR2;
        ST_TERR1: state_d = ST_TERR2;
        default:  state_d = state_q;
      endcase
    end
  end

  ahb_default_slave u_dflt (
    .err_first (state_q == ST_DERR1 || state_q == ST_TERR1),
    .err_last  (state_q == ST_DERR2 || state_q == ST_TERR2),
    .hready    (dflt_rdy),
    .hresp     (dflt_resp)
  );

  always_comb begin
    rdy  = 1'b1;
    resp = HRESP_OKAY;
    data = '0;
    case (state_q)
      ST_PASS: begin
        rdy  = HREADYOUTS;
        resp = HRESPS;
        data = HRDATAS;
      end
      ST_DERR1, ST_DERR2, ST_TERR1, ST_TERR2: begin
        rdy  = dflt_rdy;
        resp = dflt_resp;
      end
      default: ;
    endcase
  end

  // Both masters see global HREADY; only the owner sees response and data.
  assign HREADYM  = rdy;
  assign HREADYM0 = rdy;
  assign HREADYM1 = rdy;
  assign HRESPM0  = own_q[0] ? resp : HRESP_OKAY;
  assign HRESPM1  = own_q[1] ? resp : HRESP_OKAY;
  assign HRDATAM0 = own_q[0] ? data : '0;
  assign HRDATAM1 = own_q[1] ? data : '0;
  assign dp_owner = own_q;

endmodule

// File: tb/tb_ahb_resp_router.sv
// Directed scoreboard bench for ahb_resp_router; timeout vectors run when AHB_RESP_TIMEOUT_EN is defined.
module tb_ahb_resp_router;

  localparam logic [1:0] OK = 2'b00, ER = 2'b01;
  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10;

  typedef struct {
    int          idx;
    logic        rdy;
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;
    logic [1:0]  own;
    logic        irq;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [1:0]  hmsel = '0, HTRANSM = '0, HRESPS = '0;
  logic        HSELSLV = 1'b0, HREADYOUTS = 1'b0, timeout_clr = 1'b0;
  logic [31:0] HRDATAS = '0;
  logic        HREADYM, HREADYM0, HREADYM1, timeout_irq;
  logic [31:0] HRDATAM0, HRDATAM1;
  logic [1:0]  HRESPM0, HRESPM1, dp_owner;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec = 0;

  always #5 HCLK = ~HCLK;

  ahb_resp_router #(.DW(32), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hmsel(hmsel), .HTRANSM(HTRANSM), .HSELSLV(HSELSLV),
    .HRDATAS(HRDATAS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HREADYM(HREADYM),
    .HRDATAM0(HRDATAM0), .HRDATAM1(HRDATAM1), .HREADYM0(HREADYM0), .HREADYM1(HREADYM1),
    .HRESPM0(HRESPM0), .HRESPM1(HRESPM1), .dp_owner(dp_owner), .timeout_irq(timeout_irq),
    .timeout_clr(timeout_clr)
  );

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s actual=%h expected=%h", idx, nm, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge HCLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.idx, "HREADYM",     32'(HREADYM),     32'(e.rdy));
      chk(e.idx, "HREADYM0",    32'(HREADYM0),    32'(e.rdy));
      chk(e.idx, "HREADYM1",    32'(HREADYM1),    32'(e.rdy));
      chk(e.idx, "HRESPM0",     32'(HRESPM0),     32'(e.r0));
      chk(e.idx, "HRESPM1",     32'(HRESPM1),     32'(e.r1));
      chk(e.idx, "HRDATAM0",    HRDATAM0,         e.d0);
      chk(e.idx, "HRDATAM1",    HRDATAM1,         e.d1);
      chk(e.idx, "dp_owner",    32'(dp_owner),    32'(e.own));
      chk(e.idx, "timeout_irq", 32'(timeout_irq), 32'(e.irq));
    end
  end

  // rmode: 0 reset released, 1 reset held, 2 reset asserted mid-cycle.
  task automatic step(input logic [1:0] sel, input logic [1:0] tr, input logic hs,
                      input logic [31:0] rd, input logic ry, input logic [1:0] rs,
                      input logic clr, input int rmode,
                      input logic e_rdy, input logic [1:0] e_r0, input logic [1:0] e_r1,
                      input logic [31:0] e_d0, input logic [31:0] e_d1,
                      input logic [1:0] e_own, input logic e_irq);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESETn = (rmode != 1);
    hmsel = sel; HTRANSM = tr; HSELSLV = hs;
    HRDATAS = rd; HREADYOUTS = ry; HRESPS = rs; timeout_clr = clr;
    e.idx = vec; e.rdy = e_rdy; e.r0 = e_r0; e.r1 = e_r1;
    e.d0 = e_d0; e.d1 = e_d1; e.own = e_own; e.irq = e_irq;
    q.push_back(e);
    vec++;
    if (rmode == 2) begin
      #1;
      HRESETn = 1'b0;
    end
  endtask

  initial begin
    // reset state
    step(2'b00, TI, 0, 32'h0,        0, OK, 0, 1, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    // BUSY/IDLE: slave inputs ignored, zero-wait OKAY, owner still tracks hmsel
    step(2'b01, TB, 1, 32'h1234,     0, ER, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b10, TI, 1, 32'hFFFF,     0, ER, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b01, TB, 1, 32'hFFFF,     0, ER, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b10, 0);
    // M0 read hit with two waits
    step(2'b01, TN, 1, 32'hAAAA,     0, ER, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b00, TI, 0, 32'h0,        0, OK, 0, 0, 0, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b00, TI, 0, 32'h0,        0, OK, 0, 0, 0, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b00, TI, 0, 32'hDEADBEEF, 1, OK, 0, 0, 1, OK, OK, 32'hDEADBEEF, 32'h0, 2'b01, 0);
    // M1 unmapped -> default slave ERROR pair
    step(2'b10, TN, 0, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b00, TI, 0, 32'h5555,     1, OK, 0, 0, 0, OK, ER, 32'h0, 32'h0, 2'b10, 0);
    step(2'b00, TI, 0, 32'h5555,     1, OK, 0, 0, 1, OK, ER, 32'h0, 32'h0, 2'b10, 0);
    // back-to-back M0 then M1, hmsel changes on completion edge
    step(2'b01, TN, 1, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b10, TN, 1, 32'h0,        0, OK, 0, 0, 0, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b10, TN, 1, 32'h11111111, 1, OK, 0, 0, 1, OK, OK, 32'h11111111, 32'h0, 2'b01, 0);
    step(2'b00, TI, 0, 32'h22222222, 1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h22222222, 2'b10, 0);
    // hmsel=11 treated as M0; slave ERROR passed through
    step(2'b11, TN, 1, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b00, TI, 0, 32'h33333333, 1, ER, 0, 0, 1, ER, OK, 32'h33333333, 32'h0, 2'b01, 0);
    // reset mid-PASS: reset values in the same cycle
    step(2'b10, TN, 1, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b00, TI, 0, 32'h99999999, 0, OK, 0, 2, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    step(2'b00, TI, 0, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
`ifdef AHB_RESP_TIMEOUT_EN
    // slave stalls: 4 waits then TERR1/TERR2, late ready ignored, irq sticky until cleared
    step(2'b01, TN, 1, 32'h0,        0, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
    for (int i = 0; i < 4; i++)
      step(2'b00, TI, 0, 32'h0,      0, OK, 0, 0, 0, OK, OK, 32'h0, 32'h0, 2'b01, 0);
    step(2'b00, TI, 0, 32'hBBBB,     1, OK, 0, 0, 0, ER, OK, 32'h0, 32'h0, 2'b01, 1);
    step(2'b00, TI, 0, 32'hBBBB,     1, OK, 0, 0, 1, ER, OK, 32'h0, 32'h0, 2'b01, 1);
    step(2'b00, TI, 0, 32'h0,        1, OK, 1, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 1);
    step(2'b00, TI, 0, 32'h0,        1, OK, 0, 0, 1, OK, OK, 32'h0, 32'h0, 2'b00, 0);
`endif
    @(posedge HCLK);
    @(negedge HCLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
